// File: rtl/voice_sequencer.sv
// Round-robin sequencer that starts each enabled voice in turn, sums their samples into one mix,
// and lets the active voice use the shared two-stage multiplier. Define VOICE_SEQUENCER_SATURATE_EN for a clamped mix.
module voice_sequencer #(
    parameter int NUM_VOICES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_tick,
    input  logic [NUM_VOICES-1:0]    voice_en,
    output logic [NUM_VOICES-1:0]    voice_start,
    input  logic [NUM_VOICES-1:0]    voice_finish,
    input  logic [NUM_VOICES*32-1:0] voice_mult_a,
    input  logic [NUM_VOICES*32-1:0] voice_mult_b,
    output logic [63:0]              mult_p,
    input  logic [NUM_VOICES*24-1:0] voice_wave,
    output logic [23:0]              mix_out,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun
);
    localparam int CW = $clog2(NUM_VOICES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SELECT, START, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cur_q, cur_d;
    logic [NUM_VOICES-1:0]   en_q, en_d;
    logic signed [26:0]      acc_q, acc_d;
    logic [23:0]             mix_out_q, mix_out_d;
    logic                    mix_valid_q, mix_valid_d;
    logic                    overrun_q, overrun_d;
    logic [31:0]             op_a_q, op_a_d, op_b_q, op_b_d;
    logic [63:0]             prod_q, prod_d;

    logic [23:0]             sel_wave;
    logic                    sel_en, sel_fin;
    logic signed [26:0]      wave_ext;
    logic [23:0]             mix_sat;

    // Voice mux keyed on cur; cur==NUM_VOICES matches no lane, so everything reads as zero.
    always_comb begin
        op_a_d   = '0;
        op_b_d   = '0;
        sel_wave = '0;
        sel_en   = 1'b0;
        sel_fin  = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (cur_q == CW'(i)) begin
                op_a_d   = voice_mult_a[32*i +: 32];
                op_b_d   = voice_mult_b[32*i +: 32];
                sel_wave = voice_wave[24*i +: 24];
                sel_en   = en_q[i];
                sel_fin  = voice_finish[i];
            end
        end
    end

    assign wave_ext = {{3{sel_wave[23]}}, sel_wave};
    assign prod_d   = 64'(op_a_q) * 64'(op_b_q);

    always_comb begin
`ifdef VOICE_SEQUENCER_SATURATE_EN
        if (acc_q > 27'sd8388607)
            mix_sat = 24'h7FFFFF;
        else if (acc_q < -27'sd8388608)
            mix_sat = 24'h800000;
        else
            mix_sat = acc_q[23:0];
`else
        mix_sat = acc_q[23:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        en_d        = en_q;
        acc_d       = acc_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q | (sample_tick && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    en_d    = voice_en;
                    acc_d   = '0;
                    cur_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (cur_q == LAST) begin
                    mix_out_d   = mix_sat;
                    mix_valid_d = 1'b1;
                    cur_d       = '0;
                    state_d     = IDLE;
                end else if (sel_en) begin
                    state_d = START;
                end else begin
                    cur_d = cur_q + CW'(1);
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (sel_fin) begin
                    acc_d   = acc_q + wave_ext;
                    cur_d   = cur_q + CW'(1);
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        voice_start = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            voice_start[i] = (state_q == START) && (cur_q == CW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            en_q        <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            en_q        <= en_d;
            acc_q       <= acc_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            prod_q      <= prod_d;
        end
    end

    assign mult_p    = prod_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
endmodule

// File: doc/voice_sequencer.md
VOICE_SEQUENCER -- requirements
Module: voice_sequencer

Interface
REQ-001 Parameter: NUM_VOICES, default 4, number of DSP voice requesters sharing one multiplier (legal range 1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 sample_tick  input  1  one-cycle pulse requesting one output sample.
REQ-005 voice_en  input  NUM_VOICES  per-voice enable mask, sampled on an accepted tick.
REQ-006 voice_start  output  NUM_VOICES  one-hot, one-cycle start pulse to a voice.
REQ-007 voice_finish  input  NUM_VOICES  one-cycle completion pulse from each voice.
REQ-008 voice_mult_a, voice_mult_b  input  NUM_VOICES*32 each  packed per-voice multiplier operands, voice i at bits [32i+31:32i].
REQ-009 mult_p  output  64  shared multiplier product, broadcast to all voices.
REQ-010 voice_wave  input  NUM_VOICES*24  packed per-voice two's-complement sample, voice i at bits [24i+23:24i].
REQ-011 mix_out  output  24  two's-complement mixed sample.
REQ-012 mix_valid  output  1  one-cycle pulse; mix_out updated in the same cycle.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 overrun  output  1  sticky flag: tick arrived while busy.

Function
REQ-015 States SHALL be IDLE, SELECT, START, WAIT; index register cur has width clog2(NUM_VOICES+1).
REQ-016 IDLE with sample_tick: latch voice_en into en_q, clear accumulator, cur<=0, go SELECT.
REQ-017 SELECT: cur==NUM_VOICES -> load mix_out, pulse mix_valid (registered, next cycle), cur<=0, go IDLE; else en_q[cur]==1 -> go START; else cur<=cur+1, stay SELECT.
REQ-018 START: voice_start[cur]=1 for exactly this cycle, go WAIT.
REQ-019 WAIT: on voice_finish[cur], acc<=acc+sign-extended voice_wave[cur], cur<=cur+1, go SELECT; otherwise hold indefinitely.
REQ-020 voice_finish of any voice other than cur, or asserted outside WAIT, SHALL be ignored.
REQ-021 Multiplier operands SHALL be voice cur's voice_mult_a/b in every state (cur==0 in IDLE); when cur==NUM_VOICES operands are zero.
REQ-022 mult_p SHALL equal unsigned 32x32 product of operands presented exactly two cycles earlier (two register stages).
REQ-023 Accumulator width SHALL be 27 bits signed; no overflow internally for up to 8 voices.
REQ-024 Latency: mix_valid high in cycle T+NUM_VOICES+2+sum over enabled voices of (k_i+1), where T is tick cycle and k_i>=1 is cycles from start pulse to finish.
REQ-025 sample_tick while busy: tick ignored, overrun<=1, current sequence unaffected.
REQ-026 sample_tick in the cycle mix_valid is high (state IDLE) SHALL be accepted normally.
REQ-027 voice_en changes during a sequence SHALL not affect it (en_q used).
REQ-028 All-zero voice_en: mix_out<=0, mix_valid at T+NUM_VOICES+2, no start pulses.

Reset
REQ-029 On rst: state IDLE, cur 0, acc 0, en_q 0, both multiplier pipeline stages 0 (mult_p 0), mix_out 0, mix_valid 0, voice_start 0, overrun 0, busy 0.
REQ-030 rst mid-sequence SHALL abort immediately; no mix_valid for the aborted sample; next tick after rst release starts a fresh sequence.
REQ-031 overrun SHALL clear only on rst.

Configuration
REQ-032 Macro VOICE_SEQUENCER_SATURATE_EN defined: mix_out = acc clamped to [-8388608, 8388607].
REQ-033 Macro undefined: mix_out = acc[23:0] (two's-complement wrap).

Verification
REQ-034 NUM_VOICES=4, en=4'b0001, voice0 finish k=3 after start, wave=100 -> one start pulse at T+2, mix_valid at T+10, mix_out=100.
REQ-035 en=4'b1111, waves 100,-50,7,1, each k=5 -> starts to voices 0..3 in order, mix_out=58, mix_valid at T+30.
REQ-036 en=4'b1111, each wave=24'h7FFFFF -> with SATURATE_EN mix_out=24'h7FFFFF; without, mix_out=24'hFFFFFC.
REQ-037 Voice 1 drives a=3,b=5 while cur==1 -> mult_p=15 exactly two cycles later; spurious finish on voice 2 during voice 1 WAIT ignored.
REQ-038 Second tick while busy -> overrun=1, sequence completes with correct mix, overrun stays 1 until rst.
REQ-039 rst asserted during voice 2 WAIT -> all outputs zero immediately, no mix_valid; next tick runs full sequence from voice 0.
